branch_predictor_ctrl: RTL and testbench
========================================

// Module: branch_predictor_ctrl
// PURPOSE
//  Dynamic branch-prediction controller for the 5-stage RV32I pipeline; replaces the static predict-not-taken policy.
//  Holds a table of 2-bit saturating counters indexed by PC. Predicts in ID, where the branch target is known.
//  Resolves in EX and drives the redirect PC plus the IF/ID flush controls for the pipeline registers.
// PARAMETERS
//  IDX_W  4   BHT index width; table depth = 2**IDX_W entries; index = PC[IDX_W+1:2]
//  XLEN   32  PC/target width
// PORTS
//  clk              in   1     rising-edge clock
//  rst_n            in   1     synchronous active-low reset
//  ID_is_branch     in   1     instruction in ID is a B-type (opcode 1100011)
//  ID_PC            in   XLEN  PC of the instruction in ID
//  ID_target        in   XLEN  PC+immB computed in ID
//  ID_pred_taken    out  1     prediction for ID branch, carried down the pipe to EX
//  ID_redirect      out  1     fetch from ID_target next cycle
//  EX_is_branch     in   1     instruction in EX is a B-type and valid (not a bubble)
//  EX_PC            in   XLEN  PC of the EX branch
//  EX_taken         in   1     actual outcome (BrEq/BrLT combined with funct3)
//  EX_pred_taken    in   1     prediction carried from ID
//  EX_target        in   XLEN  branch target carried from ID
//  EX_redirect      out  1     misprediction; fetch from EX_redirect_pc
//  EX_redirect_pc   out  XLEN  EX_target if EX_taken, else EX_PC+4
//  redirect_pc      out  XLEN  muxed next-PC override (EX over ID)
//  IF_flush         out  1     flush IF/ID register
//  ID_flush         out  1     flush ID/EX register
//  bp_ready         out  1     table initialised, predictor active
// BEHAVIOUR
//  FSM: INIT -> RUN. rst_n=0 forces INIT, init_idx=0, bp_ready=0 (synchronous; valid mid-operation).
//  INIT: one entry per cycle written to 2'b01 (weakly not-taken); after entry 2**IDX_W-1 go to RUN.
//   bp_ready=1 from the following cycle, i.e. 2**IDX_W cycles after rst_n is released.
//  In INIT: ID_pred_taken=0, ID_redirect=0, no table updates. EX_redirect still resolves (pred=0).
//  Lookup: combinational table read at ID_PC index. ID_pred_taken = ctr[1] & ID_is_branch & bp_ready.
//  ID_redirect = ID_pred_taken & ~EX_redirect.
//  EX_redirect = EX_is_branch & (EX_taken != EX_pred_taken), combinational, zero-cycle latency.
//  Update: on EX_is_branch in RUN, ctr(EX_PC idx) +1 if taken, -1 if not; saturate at 2'b11 / 2'b00; written at clock edge.
//  Same index read and written in one cycle: lookup returns the pre-update value (read-before-write).
//  Priority: EX_redirect > ID_redirect. redirect_pc = EX_redirect ? EX_redirect_pc : ID_target.
//  Flushes: EX_redirect -> IF_flush=1, ID_flush=1. ID_redirect only -> IF_flush=1, ID_flush=0. Otherwise both 0.
//  EX_PC+4 wraps modulo 2**XLEN. Index aliasing between PCs is allowed; no tags are stored.
//  Reset values: bp_ready=0. All combinational outputs are 0 while rst_n=0, except EX_redirect_pc and redirect_pc, which follow their inputs.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
//   stat_branches counts EX_is_branch cycles; stat_mispredicts counts EX_redirect cycles.
//   Both cleared by rst_n, counted in INIT and RUN, saturate at 32'hFFFFFFFF.
//  BP_STATS_EN undefined: neither port nor counter exists.
// TESTING
//  T1 IDX_W=4, release rst_n -> bp_ready=0 for 16 cycles, 1 on cycle 17; ID_redirect=0 throughout INIT even with ID_is_branch=1.
//  T2 RUN, EX branch PC=0x40, pred=0, taken=1, target=0x80 -> EX_redirect=1, redirect_pc=0x80, IF_flush=ID_flush=1; ctr[0x40] 01->10.
//  T3 then ID_is_branch, ID_PC=0x40, ID_target=0x80 -> ID_pred_taken=1, ID_redirect=1, IF_flush=1, ID_flush=0.
//  T4 5 taken updates at PC 0x44 then 1 not-taken -> counter 11 then 10; lookup still predicts taken.
//  T5 same cycle: EX mispredict (not-taken, EX_PC=0x10 -> 0x14) and ID predicted-taken -> redirect_pc=0x14, ID_redirect=0.
//  T6 ID lookup and EX update on the same index in one cycle -> old prediction returned, new value visible next cycle;
//     with BP_STATS_EN, T2..T5 give stat_branches=8, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_predictor_ctrl.sv
// Dynamic branch predictor: 2-bit saturating counter table, ID-stage prediction, EX-stage resolution.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor_ctrl #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ID_is_branch,
    input  logic [XLEN-1:0] ID_PC,
    input  logic [XLEN-1:0] ID_target,
    output logic            ID_pred_taken,
    output logic            ID_redirect,
    input  logic            EX_is_branch,
    input  logic [XLEN-1:0] EX_PC,
    input  logic            EX_taken,
    input  logic            EX_pred_taken,
    input  logic [XLEN-1:0] EX_target,
    output logic            EX_redirect,
    output logic [XLEN-1:0] EX_redirect_pc,
    output logic [XLEN-1:0] redirect_pc,
    output logic            IF_flush,
    output logic            ID_flush,
    output logic            bp_ready
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] init_idx_q;
    logic             bp_ready_q;
    logic [1:0]       bht_q [DEPTH];

    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       id_ctr;
    logic [1:0]       ex_ctr;
    logic [1:0]       ex_ctr_d;
    logic             ex_mispredict;
    logic             unused_pc_bits;

    assign id_idx = ID_PC[IDX_W+1:2];
    assign ex_idx = EX_PC[IDX_W+1:2];
    assign id_ctr = bht_q[id_idx];
    assign ex_ctr = bht_q[ex_idx];
    assign unused_pc_bits = ^{ID_PC[XLEN-1:IDX_W+2], ID_PC[1:0]};

    always_comb begin
        ex_ctr_d = ex_ctr;
        if (EX_taken) begin
            if (ex_ctr != 2'b11) ex_ctr_d = ex_ctr + 2'b01;
        end else begin
            if (ex_ctr != 2'b00) ex_ctr_d = ex_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            bp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q    <= ST_RUN;
                        bp_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Table has no reset of its own: the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                bht_q[init_idx_q] <= 2'b01;
            end else if (EX_is_branch) begin
                bht_q[ex_idx] <= ex_ctr_d;
            end
        end
    end

    assign ex_mispredict  = rst_n & EX_is_branch & (EX_taken != EX_pred_taken);
    assign EX_redirect    = ex_mispredict;
    assign EX_redirect_pc = EX_taken ? EX_target : EX_PC + XLEN'(4);
    assign ID_pred_taken  = rst_n & bp_ready_q & ID_is_branch & id_ctr[1];
    assign ID_redirect    = ID_pred_taken & ~ex_mispredict;
    assign redirect_pc    = ex_mispredict ? EX_redirect_pc : ID_target;
    assign IF_flush       = ex_mispredict | ID_redirect;
    assign ID_flush       = ex_mispredict;
    assign bp_ready       = bp_ready_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (EX_is_branch && stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
            if (ex_mispredict && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl: directed scenarios plus randomized traffic vs. a table model.
module tb_branch_predictor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ID_is_branch;
    logic [31:0] ID_PC, ID_target;
    logic        ID_pred_taken, ID_redirect;
    logic        EX_is_branch;
    logic [31:0] EX_PC;
    logic        EX_taken, EX_pred_taken;
    logic [31:0] EX_target;
    logic        EX_redirect;
    logic [31:0] EX_redirect_pc, redirect_pc;
    logic        IF_flush, ID_flush, bp_ready;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: counter value per table slot, plus whether the predictor is active.
    int unsigned mctr [16];
    bit          mready = 0;

    always #5 clk = ~clk;

    branch_predictor_ctrl #(.IDX_W(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_is_branch(ID_is_branch), .ID_PC(ID_PC), .ID_target(ID_target),
        .ID_pred_taken(ID_pred_taken), .ID_redirect(ID_redirect),
        .EX_is_branch(EX_is_branch), .EX_PC(EX_PC), .EX_taken(EX_taken),
        .EX_pred_taken(EX_pred_taken), .EX_target(EX_target),
        .EX_redirect(EX_redirect), .EX_redirect_pc(EX_redirect_pc),
        .redirect_pc(redirect_pc), .IF_flush(IF_flush), .ID_flush(ID_flush),
        .bp_ready(bp_ready)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit taken);
        int i;
        if (!mready) return;
        i = midx(pc);
        if (taken) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
        else       mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
    endfunction

    function automatic logic [31:0] rand_pc();
        int r = $urandom_range(0, 5);
        if (r == 0) return $urandom & 32'hFFFF_FFFC;
        if (r == 1) return 32'hFFFF_FFFC;
        return 32'h100 + ($urandom_range(0, 31) * 4);
    endfunction

    task automatic set_idle();
        ID_is_branch = 0; ID_PC = 0; ID_target = 0;
        EX_is_branch = 0; EX_PC = 0; EX_taken = 0; EX_pred_taken = 0; EX_target = 0;
    endtask

    // Release reset and walk through the 16-cycle table sweep.
    task automatic wait_init();
        bit exp_exr;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            ID_is_branch = 1; ID_PC = rand_pc(); ID_target = $urandom;
            EX_is_branch = 1; EX_PC = rand_pc(); EX_taken = $urandom_range(0, 1);
            EX_pred_taken = 0; EX_target = $urandom;
            #1;
            exp_exr = EX_taken;
            cmp_cnt++;
            if (bp_ready !== 1'b0) begin
                err_cnt++; $display("FAIL init_bp_ready cycle %0d: got %b expected 0", i, bp_ready);
            end
            cmp_cnt++;
            if (ID_redirect !== 1'b0 || ID_pred_taken !== 1'b0) begin
                err_cnt++; $display("FAIL init_id_redirect cycle %0d: got %b/%b expected 0/0", i, ID_redirect, ID_pred_taken);
            end
            cmp_cnt++;
            if (EX_redirect !== exp_exr) begin
                err_cnt++; $display("FAIL init_ex_redirect cycle %0d: got %b expected %b", i, EX_redirect, exp_exr);
            end
            @(negedge clk);
        end
        set_idle();
        #1;
        cmp_cnt++;
        if (bp_ready !== 1'b1) begin
            err_cnt++; $display("FAIL init_done_bp_ready: got %b expected 1", bp_ready);
        end
        for (int i = 0; i < 16; i++) mctr[i] = 1;
        mready = 1;
        $display("init sweep done, bp_ready=%b", bp_ready);
    endtask

    task automatic test_reset();
        rst_n = 0; mready = 0;
        set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        ID_is_branch = 1; ID_PC = 32'h40; ID_target = 32'h300;
        EX_is_branch = 1; EX_PC = 32'h200; EX_taken = 1; EX_pred_taken = 0; EX_target = 32'h123;
        #1;
        cmp_cnt++;
        if ({bp_ready, EX_redirect, ID_pred_taken, ID_redirect, IF_flush, ID_flush} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bp_ready, EX_redirect, ID_pred_taken, ID_redirect, IF_flush, ID_flush});
        end
        cmp_cnt++;
        if (EX_redirect_pc !== 32'h123 || redirect_pc !== 32'h300) begin
            err_cnt++; $display("FAIL reset_pcs: got %h/%h expected 00000123/00000300", EX_redirect_pc, redirect_pc);
        end
`ifdef BP_STATS_EN
        cmp_cnt++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            err_cnt++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
        end
`endif
        $display("reset: outputs checked while rst_n=0");
        wait_init();
    endtask

    task automatic test_directed();
`ifdef BP_STATS_EN
        logic [31:0] br0, mp0;
        br0 = stat_branches; mp0 = stat_mispredicts;
`endif
        // EX mispredict on a taken branch
        @(negedge clk); set_idle();
        EX_is_branch = 1; EX_PC = 32'h40; EX_pred_taken = 0; EX_taken = 1; EX_target = 32'h80; ID_target = 32'h999;
        #1;
        cmp_cnt++;
        if ({EX_redirect, IF_flush, ID_flush} !== 3'b111 || redirect_pc !== 32'h80) begin
            err_cnt++; $display("FAIL t2_ex_mispredict: got %b pc=%h expected 111 pc=00000080", {EX_redirect, IF_flush, ID_flush}, redirect_pc);
        end
        model_update(32'h40, 1);
        $display("T2: EX redirect to %h", redirect_pc);

        // trained counter now predicts taken in ID
        @(negedge clk); set_idle();
        ID_is_branch = 1; ID_PC = 32'h40; ID_target = 32'h80;
        #1;
        cmp_cnt++;
        if ({ID_pred_taken, ID_redirect, IF_flush, ID_flush} !== 4'b1110 || redirect_pc !== 32'h80) begin
            err_cnt++; $display("FAIL t3_id_redirect: got %b pc=%h expected 1110 pc=00000080", {ID_pred_taken, ID_redirect, IF_flush, ID_flush}, redirect_pc);
        end
        $display("T3: ID predicted taken, redirect to %h", redirect_pc);

        // saturation: five taken then one not-taken must still predict taken
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); set_idle();
            EX_is_branch = 1; EX_PC = 32'h44; EX_taken = (k < 5); EX_pred_taken = EX_taken; EX_target = 32'h90;
            #1;
            cmp_cnt++;
            if (EX_redirect !== 1'b0) begin
                err_cnt++; $display("FAIL t4_no_redirect %0d: got %b expected 0", k, EX_redirect);
            end
            model_update(32'h44, EX_taken);
        end
        @(negedge clk); set_idle();
        ID_is_branch = 1; ID_PC = 32'h44; ID_target = 32'h90;
        #1;
        cmp_cnt++;
        if (ID_pred_taken !== 1'b1) begin
            err_cnt++; $display("FAIL t4_saturate: got %b expected 1", ID_pred_taken);
        end
        $display("T4: after saturation pred=%b", ID_pred_taken);

        // EX mispredict overrides an ID predicted-taken in the same cycle
        @(negedge clk); set_idle();
        EX_is_branch = 1; EX_PC = 32'h10; EX_taken = 0; EX_pred_taken = 1; EX_target = 32'h200;
        ID_is_branch = 1; ID_PC = 32'h40; ID_target = 32'h80;
        #1;
        cmp_cnt++;
        if (redirect_pc !== 32'h14 || {ID_pred_taken, ID_redirect, IF_flush, ID_flush} !== 4'b1011) begin
            err_cnt++; $display("FAIL t5_priority: got pc=%h %b expected pc=00000014 1011", redirect_pc, {ID_pred_taken, ID_redirect, IF_flush, ID_flush});
        end
        model_update(32'h10, 0);
        $display("T5: priority redirect to %h", redirect_pc);

`ifdef BP_STATS_EN
        @(negedge clk); set_idle(); #1;
        cmp_cnt++;
        if (stat_branches - br0 !== 32'd8 || stat_mispredicts - mp0 !== 32'd2) begin
            err_cnt++; $display("FAIL stats_t2_t5: got %0d/%0d expected 8/2", stat_branches - br0, stat_mispredicts - mp0);
        end
`endif

        // read-before-write on the same slot
        @(negedge clk); set_idle();
        ID_is_branch = 1; ID_PC = 32'h48; ID_target = 32'h60;
        EX_is_branch = 1; EX_PC = 32'h48; EX_taken = 1; EX_pred_taken = 1; EX_target = 32'h60;
        #1;
        cmp_cnt++;
        if (ID_pred_taken !== 1'b0) begin
            err_cnt++; $display("FAIL t6_old_value: got %b expected 0", ID_pred_taken);
        end
        model_update(32'h48, 1);
        @(negedge clk); set_idle();
        ID_is_branch = 1; ID_PC = 32'h48; ID_target = 32'h60;
        #1;
        cmp_cnt++;
        if (ID_pred_taken !== 1'b1 || ID_redirect !== 1'b1 || redirect_pc !== 32'h60) begin
            err_cnt++; $display("FAIL t6_new_value: got %b%b pc=%h expected 11 pc=00000060", ID_pred_taken, ID_redirect, redirect_pc);
        end
        $display("T6: same-slot read returned old then new value");
    endtask

    task automatic test_random();
        bit          e_exr, e_idp, e_idr;
        logic [31:0] e_expc, e_rpc;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ID_is_branch = ($urandom_range(0, 3) != 0); ID_PC = rand_pc(); ID_target = $urandom;
            EX_is_branch = ($urandom_range(0, 3) != 0);
            EX_PC = ($urandom_range(0, 3) == 0) ? ID_PC : rand_pc();
            EX_taken = $urandom_range(0, 1);
            EX_pred_taken = ($urandom_range(0, 2) == 0) ? ~EX_taken : (mctr[midx(EX_PC)] >= 2);
            EX_target = $urandom;
            #1;
            e_exr  = EX_is_branch && (EX_taken != EX_pred_taken);
            e_idp  = mready && ID_is_branch && (mctr[midx(ID_PC)] >= 2);
            e_idr  = e_idp && !e_exr;
            e_expc = EX_taken ? EX_target : EX_PC + 32'd4;
            e_rpc  = e_exr ? e_expc : ID_target;
            cmp_cnt++;
            if ({EX_redirect, ID_pred_taken, ID_redirect, IF_flush, ID_flush, bp_ready} !==
                {e_exr, e_idp, e_idr, e_exr | e_idr, e_exr, 1'b1}) begin
                err_cnt++;
                $display("FAIL rand_flags %0d: got %b expected %b", n,
                         {EX_redirect, ID_pred_taken, ID_redirect, IF_flush, ID_flush, bp_ready},
                         {e_exr, e_idp, e_idr, e_exr | e_idr, e_exr, 1'b1});
            end
            cmp_cnt++;
            if (EX_redirect_pc !== e_expc || redirect_pc !== e_rpc) begin
                err_cnt++; $display("FAIL rand_pcs %0d: got %h/%h expected %h/%h", n, EX_redirect_pc, redirect_pc, e_expc, e_rpc);
            end
            if (EX_is_branch) model_update(EX_PC, EX_taken);
        end
        set_idle();
        $display("random: 400 cycles of mixed ID/EX traffic checked");
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); set_idle();
            EX_is_branch = 1; EX_PC = 32'h40; EX_taken = 1; EX_pred_taken = 1; EX_target = 32'h80;
            model_update(32'h40, 1);
        end
        @(negedge clk); set_idle();
        rst_n = 0; mready = 0;
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (bp_ready !== 1'b0) begin
            err_cnt++; $display("FAIL midreset_bp_ready: got %b expected 0", bp_ready);
        end
        wait_init();
        @(negedge clk); set_idle();
        ID_is_branch = 1; ID_PC = 32'h40; ID_target = 32'h80;
        #1;
        cmp_cnt++;
        if (ID_pred_taken !== 1'b0) begin
            err_cnt++; $display("FAIL midreset_table_cleared: got %b expected 0", ID_pred_taken);
        end
        $display("midreset: table reinitialised, pred=%b", ID_pred_taken);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
